car_lane_hazard: RTL and testbench

- One horizontally moving car on a fixed tile row of the 20x15 tile (32 px) Frogger playfield.
- Advances the car on a slow tick and wraps it at the playfield edge.
- Flags when the current VGA tile holds the car.
- Detects a frog/car collision as a registered level, consumed by the frog controller. Sits between the frog controller and the video mux in the game top.

---
 rtl/car_lane_hazard.sv | 106 ++++++++++
 tb/tb_car_lane_hazard.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/car_lane_hazard.sv
// Single Frogger lane car: slow-tick mover with tile wrap, VGA tile flag and frog collision.
// Define CAR_REVERSE_EN to move the car leftward (subtract modulo lane width).
module car_lane_hazard #(
    parameter int c_CAR_SPEED  = 1,
    parameter int c_MAX_X      = 20,
    parameter int c_SLOW_COUNT = 10000000,
    parameter int c_INIT_X     = 0,
    parameter int c_INIT_Y     = 12
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    input  logic [5:0] i_Frogger_Orig_X,
    input  logic [5:0] i_Frogger_Orig_Y,
    output logic [5:0] o_Car_X,
    output logic [5:0] o_Car_Y,
    output logic       o_Step,
    output logic       o_Car_Pixel,
    output logic       o_Collided
);

    localparam int CW = $clog2(c_SLOW_COUNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(c_SLOW_COUNT - 1);
    localparam logic [6:0] SPEED7 = 7'(c_CAR_SPEED);
    localparam logic [6:0] MAX7   = 7'(c_MAX_X);
    localparam logic [5:0] SPEED6 = 6'(c_CAR_SPEED);
    localparam logic [5:0] INIT_X = 6'(c_INIT_X);
    localparam logic [5:0] INIT_Y = 6'(c_INIT_Y);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    x_q, x_d;
    logic          step_q, step_d;
    logic          coll_q, coll_d;
    logic [5:0]    x_nxt;
    logic          hit;

`ifdef CAR_REVERSE_EN
    always_comb begin
        if ({1'b0, x_q} >= SPEED7) begin
            x_nxt = x_q - SPEED6;
        end else begin
            x_nxt = 6'(MAX7 - (SPEED7 - {1'b0, x_q}));
        end
    end
`else
    logic [6:0] sum;

    always_comb begin
        sum = {1'b0, x_q} + SPEED7;
        if (sum < MAX7) begin
            x_nxt = sum[5:0];
        end else begin
            x_nxt = 6'(sum - MAX7);
        end
    end
`endif

    // Spawn tile is always safe, even if the car sits on it.
    always_comb begin
        hit = (i_Frogger_X == x_q) && (i_Frogger_Y == INIT_Y) &&
              !((i_Frogger_X == i_Frogger_Orig_X) &&
                (i_Frogger_Y == i_Frogger_Orig_Y));
    end

    always_comb begin
        cnt_d  = cnt_q;
        x_d    = x_q;
        step_d = 1'b0;
        coll_d = hit;
        if (i_Enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                x_d    = x_nxt;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q  <= '0;
            x_q    <= INIT_X;
            step_q <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            step_q <= step_d;
            coll_q <= coll_d;
        end
    end

    assign o_Car_X     = x_q;
    assign o_Car_Y     = INIT_Y;
    assign o_Step      = step_q;
    assign o_Collided  = coll_q;
    assign o_Car_Pixel = ({1'b0, i_Col_Count_Div} == x_q) &&
                         ({1'b0, i_Row_Count_Div} == INIT_Y);

endmodule

// File: tb/tb_car_lane_hazard.sv
// Random and directed bench for car_lane_hazard against an arithmetic lane model.
module tb_car_lane_hazard;

    localparam int SPEED = 1;
    localparam int MAXX  = 20;
    localparam int SLOW  = 4;
    localparam int IX    = 0;
    localparam int IY    = 12;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] col;
    logic [4:0] row;
    logic [5:0] fx, fy, ox, oy;
    logic [5:0] car_x, car_y;
    logic       step, pix, coll;

    int checks;
    int errors;
    int en_cycles;

    car_lane_hazard #(
        .c_CAR_SPEED (SPEED),
        .c_MAX_X     (MAXX),
        .c_SLOW_COUNT(SLOW),
        .c_INIT_X    (IX),
        .c_INIT_Y    (IY)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_L         (rst_n),
        .i_Enable        (en),
        .i_Col_Count_Div (col),
        .i_Row_Count_Div (row),
        .i_Frogger_X     (fx),
        .i_Frogger_Y     (fy),
        .i_Frogger_Orig_X(ox),
        .i_Frogger_Orig_Y(oy),
        .o_Car_X         (car_x),
        .o_Car_Y         (car_y),
        .o_Step          (step),
        .o_Car_Pixel     (pix),
        .o_Collided      (coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Car position is just the number of completed steps, scaled and wrapped.
    function automatic int model_x(input int n);
        int s;
        s = ((n / SLOW) * SPEED) % MAXX;
`ifdef CAR_REVERSE_EN
        return (IX - s + MAXX) % MAXX;
`else
        return (IX + s) % MAXX;
`endif
    endfunction

    task automatic cycle();
        int xb;
        int hit;
        int stp;
        xb  = model_x(en_cycles);
        hit = (int'(fx) == xb && int'(fy) == IY &&
               !(fx == ox && fy == oy)) ? 1 : 0;
        stp = 0;
        if (en) begin
            en_cycles++;
            stp = (en_cycles % SLOW == 0) ? 1 : 0;
        end
        @(posedge clk);
        #1;
        check("car_x", int'(car_x), model_x(en_cycles));
        check("car_y", int'(car_y), IY);
        check("step", int'(step), stp);
        check("collided", int'(coll), hit);
    endtask

    task automatic pix_check(input int c, input int r);
        int exp;
        col = 5'(c);
        row = 5'(r);
        #1;
        exp = (c == model_x(en_cycles) && r == IY) ? 1 : 0;
        check($sformatf("pixel_%0d_%0d", c, r), int'(pix), exp);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        en_cycles = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        col   = '0;
        row   = '0;
        fx    = 6'd5;
        fy    = 6'd12;
        ox    = 6'd10;
        oy    = 6'd14;
        #12;
        check("rst_x", int'(car_x), IX);
        check("rst_y", int'(car_y), IY);
        check("rst_step", int'(step), 0);
        check("rst_coll", int'(coll), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Walk the car past the frog at (5,12) up to X=7.
        while (model_x(en_cycles) != 7 && en_cycles < 200) begin
            cycle();
        end
        check("reach_x7", int'(car_x), 7);

        // Asynchronous reset lands between clock edges, frog sits on car.
        fx = 6'd7;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_x", int'(car_x), IX);
        check("async_y", int'(car_y), IY);
        check("async_step", int'(step), 0);
        check("async_coll", int'(coll), 0);
        @(posedge clk);
        #1;
        check("held_x", int'(car_x), IX);
        en_cycles = 0;
        fx = 6'd0;
        fy = 6'd12;
        ox = 6'd0;
        oy = 6'd12;
        rst_n = 1'b1;

        // Full wrap with the frog parked on its (safe) spawn tile.
        for (int i = 0; i < 84; i++) begin
            if (model_x(en_cycles) == 3) begin
                pix_check(3, 12);
                pix_check(3, 11);
                pix_check(4, 12);
                pix_check(31, 31);
            end
            cycle();
        end

        // Freeze at count 2, then resume.
        cycle();
        cycle();
        en = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        en = 1'b1;
        cycle();
        cycle();
        check("resume_step", int'(step), 1);

        for (int i = 0; i < 600; i++) begin
            int mx;
            mx = model_x(en_cycles);
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: fx = 6'(mx);
                1: fx = 6'((mx + 1) % MAXX);
                2: fx = 6'($urandom_range(0, 63));
                default: fx = 6'($urandom_range(0, MAXX - 1));
            endcase
            fy = ($urandom_range(0, 2) != 0) ? 6'(IY) : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) begin
                ox = fx;
                oy = fy;
            end else begin
                ox = 6'($urandom_range(0, MAXX - 1));
                oy = 6'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 1) == 0) begin
                pix_check(mx, ($urandom_range(0, 1) == 0) ? IY : int'($urandom_range(0, 31)));
            end else begin
                pix_check(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
